regfile_init: RTL and testbench
===============================

# regfile_init

General-purpose register file of the MartianMIPS core: the responder on the decode stage's two-port register read interface and the target of the write-back stage's single write port. It holds 31 writable 32-bit registers plus a hard-wired zero register. Storage is an unreset array suitable for distributed RAM, so after every reset a sequential init sweep clears it while holding the pipeline stalled. Reads are combinational so decode can forward or use operands in the same cycle.

## Interface
Parameters:
- DATA_W, 32, register width (matches `RegDataBus`)
- ADDR_W, 5, register address width (matches `RegAddrBus`); NUM_REGS = 2**ADDR_W

Ports:
- clk  input  1  core clock, rising edge
- rst  input  1  reset; asynchronous, active-low (0 = in reset)
- we_i  input  1  write enable from write-back
- waddr_i  input  ADDR_W  write address
- wdata_i  input  DATA_W  write data
- re1_i  input  1  read enable, port 1 (decode re1_o)
- raddr1_i  input  ADDR_W  read address, port 1
- rdata1_o  output  DATA_W  read data, port 1 (combinational)
- re2_i  input  1  read enable, port 2
- raddr2_i  input  ADDR_W  read address, port 2
- rdata2_o  output  DATA_W  read data, port 2 (combinational)
- stall_req_o  output  1  pipeline stall request; high while not in RUN
- init_done_o  output  1  registered; high in RUN

## Operation
- State machine, two states: INIT, RUN. Registered init pointer ptr (ADDR_W bits).
- rst low (async): state=INIT, ptr=1, init_done_o=0. Array contents undefined, never directly reset.
- INIT: each rising edge writes 0 to reg[ptr], ptr increments; on the edge where ptr==NUM_REGS-1 (reg 31 cleared), state goes to RUN, init_done_o=1. ptr wrap not reached.
- INIT: write port ignored entirely; rdata1_o=rdata2_o=0 regardless of inputs; stall_req_o=1.
- RUN: on rising edge, if we_i=1 and waddr_i!=0, reg[waddr_i] <= wdata_i. Writes to address 0 are discarded.
- RUN read, per port n independently, priority order:
  - re_n=0 -> 0
  - raddr_n=0 -> 0
  - bypass hit (see Configuration) -> wdata_i
  - else reg[raddr_n]
- Both ports may read the same address simultaneously; both return the same value.
- rst asserted mid-INIT or mid-RUN: immediately back to INIT, ptr=1; full sweep repeated; prior contents lost.
- stall_req_o = ~init_done_o (combinational from state).

## Timing
- Reset values: stall_req_o=1, init_done_o=0, rdata1_o=rdata2_o=0.
- Read latency: 0 cycles (combinational address-to-data path).
- Write latency: value visible at the array output after the write edge (next cycle); same-cycle visibility only via bypass.
- Init sweep: exactly NUM_REGS-1 = 31 rising edges after rst deasserts; init_done_o rises after edge 31, stall_req_o falls same time.
- rst deassertion is synchronised externally; first sweep edge is the first rising clk with rst=1.

## Configuration
- Macro REGFILE_BYPASS_EN.
- Defined: in RUN, if we_i=1, waddr_i!=0, re_n=1 and raddr_n==waddr_i, rdata_n_o=wdata_i in the same cycle (write-back to decode forwarding, closing the three-instruction-distance hazard).
- Undefined: no bypass; reads return the array's pre-edge value; software/pipeline must tolerate the one-cycle gap. All other behaviour identical.

## Test plan
- Reset then sweep: hold rst=0 3 cycles, release -> stall_req_o=1 for 31 edges, init_done_o=1 after edge 31; reading every address 1..31 returns 0x00000000.
- Zero register: in RUN write we_i=1, waddr_i=0, wdata_i=0xDEADBEEF -> next cycle read raddr=0 returns 0; re=0 on any address returns 0.
- Write/read: write reg 5 = 0x12345678 -> next cycle rdata1_o (raddr1_i=5) and rdata2_o (raddr2_i=5) both 0x12345678.
- Bypass: reg 7 holds 0x1; same cycle we_i=1, waddr_i=7, wdata_i=0xA5A5A5A5, raddr1_i=7 -> rdata1_o=0xA5A5A5A5 with REGFILE_BYPASS_EN, 0x00000001 without.
- Writes during INIT: drive we_i=1, waddr_i=3, wdata_i=0xFFFFFFFF throughout sweep -> after init_done_o, reg 3 reads 0.
- Mid-operation reset: write reg 9 = 0xCAFEF00D, pulse rst low 1 cycle -> stall_req_o high immediately, 31-edge sweep repeats, reg 9 reads 0.

Source files
------------

// File: rtl/regfile_init_if.sv
// rtl/regfile_init_if.sv - register file write/read/status bundle
//
// Purpose: groups the write-back write port, the two decode read ports and
// the stall/init status of the register file into one interface.
//
// Signals:
//   we_i, waddr_i, wdata_i    write port (write-back stage)
//   re1_i, raddr1_i, rdata1_o read port 1 (rdata combinational)
//   re2_i, raddr2_i, rdata2_o read port 2 (rdata combinational)
//   stall_req_o               high while the init sweep is running
//   init_done_o               registered, high once the file is usable
//
// Modports:
//   master - pipeline side (drives write/read requests)
//   slave  - register file side
interface regfile_init_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              we_i;
  logic [ADDR_W-1:0] waddr_i;
  logic [DATA_W-1:0] wdata_i;
  logic              re1_i;
  logic [ADDR_W-1:0] raddr1_i;
  logic [DATA_W-1:0] rdata1_o;
  logic              re2_i;
  logic [ADDR_W-1:0] raddr2_i;
  logic [DATA_W-1:0] rdata2_o;
  logic              stall_req_o;
  logic              init_done_o;

  modport master (
    output we_i, waddr_i, wdata_i,
    output re1_i, raddr1_i, re2_i, raddr2_i,
    input  rdata1_o, rdata2_o, stall_req_o, init_done_o
  );

  modport slave (
    input  we_i, waddr_i, wdata_i,
    input  re1_i, raddr1_i, re2_i, raddr2_i,
    output rdata1_o, rdata2_o, stall_req_o, init_done_o
  );
endinterface

// File: rtl/regfile_init.sv
// rtl/regfile_init.sv - 2-read/1-write register file with post-reset clear sweep
//
// Purpose: general-purpose register file with a hard-wired zero register.
// The storage array has no reset so it can map onto distributed RAM; after
// every reset an INIT sweep writes zero to registers 1..NUM_REGS-1, one per
// clock, while stall_req_o holds the pipeline. Reads are combinational.
//
// Optional feature: macro REGFILE_BYPASS_EN enables write-to-read forwarding
// (a read of the register being written this cycle returns wdata_i).
//
// Ports:
//   clk  - core clock, rising edge
//   rst  - asynchronous active-low reset (0 = in reset)
//   bus  - regfile_init_if.slave: write port, two read ports, stall/init status
module regfile_init #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic           clk,
  input  logic           rst,
  regfile_init_if.slave  bus
);

  localparam int NUM_REGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic              init_done;

  logic [DATA_W-1:0] mem [0:NUM_REGS-1];

  logic              wr_ok;
  logic              hit1;
  logic              hit2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;

  // Sweep controller. The pointer starts at 1 because register 0 is never
  // stored; the sweep ends on the edge that clears the last register, so the
  // pointer never wraps while in INIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= INIT;
      ptr       <= ADDR_W'(1);
      init_done <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          ptr <= ptr + ADDR_W'(1);
          if (ptr == LAST_REG) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN: begin
          state     <= RUN;
          init_done <= 1'b1;
        end
        default: begin
          state     <= INIT;
          ptr       <= ADDR_W'(1);
          init_done <= 1'b0;
        end
      endcase
    end
  end

  // Write-back writes only count in RUN and never touch register 0.
  assign wr_ok = (state == RUN) && bus.we_i && (bus.waddr_i != '0);

  // Storage array: deliberately unreset. Writes are suppressed while rst is
  // held low so the sweep starts cleanly on the first edge after release.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state == INIT) begin
        mem[ptr] <= '0;
      end else if (wr_ok) begin
        mem[bus.waddr_i] <= bus.wdata_i;
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign hit1 = wr_ok && (bus.raddr1_i == bus.waddr_i);
  assign hit2 = wr_ok && (bus.raddr2_i == bus.waddr_i);
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif

  // Read ports: disabled port, zero register and INIT all return 0; a
  // bypass hit (when enabled) overrides the stale array value.
  always_comb begin
    rdata1 = '0;
    if ((state == RUN) && bus.re1_i && (bus.raddr1_i != '0)) begin
      if (hit1) begin
        rdata1 = bus.wdata_i;
      end else begin
        rdata1 = mem[bus.raddr1_i];
      end
    end
  end

  always_comb begin
    rdata2 = '0;
    if ((state == RUN) && bus.re2_i && (bus.raddr2_i != '0)) begin
      if (hit2) begin
        rdata2 = bus.wdata_i;
      end else begin
        rdata2 = mem[bus.raddr2_i];
      end
    end
  end

  assign bus.rdata1_o    = rdata1;
  assign bus.rdata2_o    = rdata2;
  assign bus.init_done_o = init_done;
  assign bus.stall_req_o = (state != RUN);

endmodule

// File: tb/tb_regfile_init.sv
// tb/tb_regfile_init.sv - self-checking bench for regfile_init
module tb_regfile_init;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam int SWEEP    = NUM_REGS - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int checks = 0;
  int errors = 0;

  regfile_init_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_init #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: counts edges since reset release; after SWEEP edges the
  // file is usable and every register reads zero.
  logic [DATA_W-1:0] mreg [NUM_REGS];
  bit                m_run = 1'b0;
  int                m_cnt = 0;

  always @(negedge rst) begin
    m_run = 1'b0;
    m_cnt = 0;
  end

  always @(posedge clk) begin
    if (!rst) begin
      m_run = 1'b0;
      m_cnt = 0;
    end else if (!m_run) begin
      m_cnt++;
      if (m_cnt == SWEEP) begin
        m_run = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) mreg[i] = '0;
      end
    end else if (bus.we_i && bus.waddr_i != 0) begin
      mreg[bus.waddr_i] = bus.wdata_i;
    end
  end

  function automatic logic [DATA_W-1:0] m_read(input logic re, input logic [ADDR_W-1:0] ra);
    if (!m_run || !re || ra == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (bus.we_i && bus.waddr_i != 0 && ra == bus.waddr_i) return bus.wdata_i;
`endif
    return mreg[ra];
  endfunction

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    chk("stall_req_o", {31'd0, bus.stall_req_o}, {31'd0, !m_run});
    chk("init_done_o", {31'd0, bus.init_done_o}, {31'd0, m_run});
    chk("rdata1_o", bus.rdata1_o, m_read(bus.re1_i, bus.raddr1_i));
    chk("rdata2_o", bus.rdata2_o, m_read(bus.re2_i, bus.raddr2_i));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we_i = 0; bus.waddr_i = '0; bus.wdata_i = '0;
    bus.re1_i = 0; bus.raddr1_i = '0; bus.re2_i = 0; bus.raddr2_i = '0;
  endtask

  // Waits for init_done_o, returns the number of edges taken (bounded).
  task automatic wait_sweep(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (bus.init_done_o) begin
        n = i;
        break;
      end
    end
  endtask

  int n;
  logic [DATA_W-1:0] exp_byp;

  initial begin
    idle();
    // Writes attempted throughout reset and sweep must be ignored.
    bus.we_i = 1; bus.waddr_i = 5'd3; bus.wdata_i = 32'hFFFF_FFFF;
    bus.re1_i = 1; bus.raddr1_i = 5'd3; bus.re2_i = 1; bus.raddr2_i = 5'd17;
    repeat (3) step();
    @(negedge clk);
    chk("reset stall", {31'd0, bus.stall_req_o}, 32'd1);
    chk("reset init_done", {31'd0, bus.init_done_o}, 32'd0);
    chk("reset rdata1", bus.rdata1_o, 32'd0);
    chk("reset rdata2", bus.rdata2_o, 32'd0);

    @(posedge clk); #1;
    rst = 1;
    wait_sweep(n);
    chk("sweep edges", n, SWEEP);
    bus.we_i = 0;
    for (int a = 1; a < NUM_REGS; a++) begin
      bus.raddr1_i = a[ADDR_W-1:0];
      bus.raddr2_i = 5'(NUM_REGS - a);
      #1;
      chk("post-sweep rd1", bus.rdata1_o, 32'd0);
      chk("post-sweep rd2", bus.rdata2_o, 32'd0);
      step();
    end

    // Zero register.
    bus.we_i = 1; bus.waddr_i = 5'd0; bus.wdata_i = 32'hDEAD_BEEF;
    step();
    bus.we_i = 0; bus.raddr1_i = 5'd0; bus.raddr2_i = 5'd0;
    #1;
    chk("zero reg rd1", bus.rdata1_o, 32'd0);
    chk("zero reg rd2", bus.rdata2_o, 32'd0);

    // Write then read on both ports.
    bus.we_i = 1; bus.waddr_i = 5'd5; bus.wdata_i = 32'h1234_5678;
    bus.raddr1_i = 5'd1; bus.raddr2_i = 5'd1;
    step();
    bus.we_i = 0; bus.raddr1_i = 5'd5; bus.raddr2_i = 5'd5;
    #1;
    chk("reg5 rd1", bus.rdata1_o, 32'h1234_5678);
    chk("reg5 rd2", bus.rdata2_o, 32'h1234_5678);
    bus.re1_i = 0;
    #1;
    chk("re1=0 on reg5", bus.rdata1_o, 32'd0);
    bus.re1_i = 1;

    // Bypass.
    bus.we_i = 1; bus.waddr_i = 5'd7; bus.wdata_i = 32'h0000_0001;
    step();
    bus.wdata_i = 32'hA5A5_A5A5; bus.raddr1_i = 5'd7;
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_byp = 32'hA5A5_A5A5;
`else
    exp_byp = 32'h0000_0001;
`endif
    chk("bypass rd1", bus.rdata1_o, exp_byp);
    step();
    bus.we_i = 0;
    #1;
    chk("reg7 after write", bus.rdata1_o, 32'hA5A5_A5A5);

    // Randomised traffic, checked every cycle by the compare process.
    for (int c = 0; c < 600; c++) begin
      bus.we_i     = ($urandom_range(0, 3) != 0);
      bus.waddr_i  = 5'($urandom_range(0, 31));
      bus.wdata_i  = $urandom;
      bus.re1_i    = ($urandom_range(0, 7) != 0);
      bus.re2_i    = ($urandom_range(0, 7) != 0);
      bus.raddr1_i = ($urandom_range(0, 3) == 0) ? bus.waddr_i : 5'($urandom_range(0, 31));
      bus.raddr2_i = ($urandom_range(0, 3) == 0) ? bus.raddr1_i : 5'($urandom_range(0, 31));
      step();
    end

    // Mid-operation reset.
    bus.we_i = 1; bus.waddr_i = 5'd9; bus.wdata_i = 32'hCAFE_F00D;
    bus.re1_i = 1; bus.raddr1_i = 5'd9; bus.re2_i = 1; bus.raddr2_i = 5'd9;
    step();
    bus.we_i = 0;
    #1;
    chk("reg9 before reset", bus.rdata2_o, 32'hCAFE_F00D);
    rst = 0;
    #1;
    chk("stall on reset", {31'd0, bus.stall_req_o}, 32'd1);
    chk("rd1 in reset", bus.rdata1_o, 32'd0);
    step();
    rst = 1;
    wait_sweep(n);
    chk("second sweep edges", n, SWEEP);
    #1;
    chk("reg9 after reset", bus.rdata1_o, 32'd0);
    chk("reg9 after reset p2", bus.rdata2_o, 32'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
